// File: rtl/mem_stage_ctrl_if.sv
// Data-cache side of the memory stage: request/response handshake plus coherence snoop.
// The master is the memory-stage controller and the slave is the dcache.
interface mem_stage_ctrl_if;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic        dhit;
  logic [31:0] dload;
  logic        ccinv;
  logic [31:0] ccsnoopaddr;

  modport master (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dload, ccinv, ccsnoopaddr
  );

  modport slave (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dload, ccinv, ccsnoopaddr
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues dcache requests, stalls the upstream pipe on a miss,
// tracks the LL/SC link register and registers the MEM/WB fields.
module mem_stage_ctrl (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    ex_valid,
  input  logic                    ex_dREN,
  input  logic                    ex_dWEN,
  input  logic                    ex_ll,
  input  logic                    ex_sc,
  input  logic [31:0]             ex_addr,
  input  logic [31:0]             ex_store,
  input  logic [2:0]              ex_final_mux,
  input  logic [31:0]             ex_out_port,
  input  logic [31:0]             ex_next_memaddr,
  input  logic [31:0]             ex_u_type,
  input  logic                    ex_halt,
  input  logic [4:0]              ex_rd,
  input  logic                    ex_regwen,
  mem_stage_ctrl_if.master        dc,
  output logic                    mem_stall,
  output logic                    wb_valid,
  output logic                    wb_regwen,
  output logic                    wb_temp_halt,
  output logic [2:0]              wb_final_mux,
  output logic [31:0]             wb_dmemload,
  output logic [31:0]             wb_out_port,
  output logic [31:0]             wb_next_memaddr,
  output logic [31:0]             wb_u_type,
  output logic [4:0]              wb_rd
);

  typedef enum logic [1:0] {StIdle, StWait, StHalted} state_e;

  state_e      state_q;
  logic        link_valid_q;
  logic [29:0] link_addr_q;

  logic mem_op, is_store, is_load, is_sc;
  logic link_match, sc_fail, halt_now, req, complete;
  logic ll_inv, link_inv;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{ex_addr[1:0], dc.ccsnoopaddr[1:0]};

  assign mem_op     = ex_valid & (ex_dREN | ex_dWEN);
  assign is_store   = ex_dWEN;
  assign is_load    = ex_dREN & ~ex_dWEN;
  assign is_sc      = ex_valid & ex_sc & ex_dWEN;
  assign link_match = link_valid_q & (link_addr_q == ex_addr[31:2]);
  // Re-evaluated every cycle, so an SC waiting in StWait fails once a snoop kills the link.
  assign sc_fail    = is_sc & ~link_match;
  assign halt_now   = (state_q == StIdle) & ex_valid & ex_halt;

  // Halt takes priority over any memory request; nRST gates requests asynchronously.
  assign req = nRST & (state_q != StHalted) & mem_op & ~sc_fail & ~halt_now;

  assign dc.dmemREN   = req & is_load;
  assign dc.dmemWEN   = req & is_store;
  assign dc.dmemaddr  = {ex_addr[31:2], 2'b00};
  assign dc.dmemstore = ex_store;

  assign mem_stall = req & ~dc.dhit;
  assign complete  = (state_q != StHalted) & ~mem_stall;

  assign ll_inv   = dc.ccinv & (dc.ccsnoopaddr[31:2] == ex_addr[31:2]);
  assign link_inv = dc.ccinv & (dc.ccsnoopaddr[31:2] == link_addr_q);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q         <= StIdle;
      link_valid_q    <= 1'b0;
      link_addr_q     <= '0;
      wb_valid        <= 1'b0;
      wb_regwen       <= 1'b0;
      wb_temp_halt    <= 1'b0;
      wb_final_mux    <= '0;
      wb_dmemload     <= '0;
      wb_out_port     <= '0;
      wb_next_memaddr <= '0;
      wb_u_type       <= '0;
      wb_rd           <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (halt_now) begin
            state_q <= StHalted;
          end else if (mem_stall) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (!mem_stall) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StHalted;
      endcase

      // A snoop hitting the address being linked wins over the LL itself.
      if (dc.dmemREN & ex_ll & dc.dhit) begin
        link_addr_q  <= ex_addr[31:2];
        link_valid_q <= ~ll_inv;
      end else if ((dc.dmemWEN & ex_sc & dc.dhit) | link_inv) begin
        link_valid_q <= 1'b0;
      end

      if (complete) begin
        wb_valid        <= ex_valid;
        wb_regwen       <= ex_regwen;
        wb_temp_halt    <= halt_now;
        wb_final_mux    <= ex_final_mux;
        wb_dmemload     <= dc.dmemREN ? dc.dload : 32'h0;
        wb_out_port     <= is_sc ? {31'h0, req & dc.dhit} : ex_out_port;
        wb_next_memaddr <= ex_next_memaddr;
        wb_u_type       <= ex_u_type;
        wb_rd           <= ex_rd;
      end else begin
        wb_valid     <= 1'b0;
        wb_regwen    <= 1'b0;
        wb_temp_halt <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl against a transaction-level model of the link
// register, dcache latency and MEM/WB latch.
module tb_mem_stage_ctrl;
  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        ex_valid, ex_dREN, ex_dWEN, ex_ll, ex_sc, ex_halt, ex_regwen;
  logic [31:0] ex_addr, ex_store, ex_out_port, ex_next_memaddr, ex_u_type;
  logic [2:0]  ex_final_mux;
  logic [4:0]  ex_rd;
  logic        mem_stall, wb_valid, wb_regwen, wb_temp_halt;
  logic [2:0]  wb_final_mux;
  logic [31:0] wb_dmemload, wb_out_port, wb_next_memaddr, wb_u_type;
  logic [4:0]  wb_rd;

  mem_stage_ctrl_if dc_if ();

  mem_stage_ctrl dut (
    .CLK(CLK), .nRST(nRST),
    .ex_valid(ex_valid), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_ll(ex_ll), .ex_sc(ex_sc),
    .ex_addr(ex_addr), .ex_store(ex_store), .ex_final_mux(ex_final_mux),
    .ex_out_port(ex_out_port), .ex_next_memaddr(ex_next_memaddr), .ex_u_type(ex_u_type),
    .ex_halt(ex_halt), .ex_rd(ex_rd), .ex_regwen(ex_regwen),
    .dc(dc_if),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_regwen(wb_regwen),
    .wb_temp_halt(wb_temp_halt), .wb_final_mux(wb_final_mux), .wb_dmemload(wb_dmemload),
    .wb_out_port(wb_out_port), .wb_next_memaddr(wb_next_memaddr), .wb_u_type(wb_u_type),
    .wb_rd(wb_rd)
  );

  always #5 CLK = ~CLK;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  bit          m_link_valid = 1'b0;
  logic [29:0] m_link_addr = '0;
  bit          m_halted = 1'b0;
  logic        e_valid = 0, e_regwen = 0, e_halt = 0;
  logic [2:0]  e_fm = '0;
  logic [31:0] e_load = '0, e_out = '0, e_nma = '0, e_ut = '0;
  logic [4:0]  e_rd = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_wb();
    check_eq("wb_valid", {31'h0, wb_valid}, {31'h0, e_valid});
    check_eq("wb_regwen", {31'h0, wb_regwen}, {31'h0, e_regwen});
    check_eq("wb_temp_halt", {31'h0, wb_temp_halt}, {31'h0, e_halt});
    check_eq("wb_final_mux", {29'h0, wb_final_mux}, {29'h0, e_fm});
    check_eq("wb_dmemload", wb_dmemload, e_load);
    check_eq("wb_out_port", wb_out_port, e_out);
    check_eq("wb_next_memaddr", wb_next_memaddr, e_nma);
    check_eq("wb_u_type", wb_u_type, e_ut);
    check_eq("wb_rd", {27'h0, wb_rd}, {27'h0, e_rd});
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = 32'h100;
      1:       r = 32'h104;
      2:       r = 32'h200;
      default: r = 32'h204;
    endcase
    r[1:0] = 2'($urandom_range(0, 3));
    return r;
  endfunction

  task automatic set_ex(input bit v, input bit ren, input bit wen, input bit ll, input bit sc,
                        input bit halt, input logic [31:0] addr, input logic [31:0] st);
    logic [31:0] r;
    r = $urandom;
    ex_valid = v; ex_dREN = ren; ex_dWEN = wen; ex_ll = ll; ex_sc = sc; ex_halt = halt;
    ex_addr = addr; ex_store = st;
    ex_final_mux = r[2:0]; ex_rd = r[7:3]; ex_regwen = r[8];
    ex_out_port = $urandom; ex_next_memaddr = $urandom; ex_u_type = $urandom;
  endtask

  // Present the current ex op (entered just after a negedge) until the model says it completes.
  task automatic run_op(input int lat, input int inv_k, input logic [31:0] inv_addr);
    bit memop, ld, st, ll, sc, lm, hit, inv, halt_now, req, stall;
    logic [31:0] dl;
    for (int k = 0; k < 8; k++) begin
      dl  = $urandom;
      hit = (k == lat);
      inv = (k == inv_k);
      dc_if.dhit = hit; dc_if.dload = dl; dc_if.ccinv = inv; dc_if.ccsnoopaddr = inv_addr;
      memop    = ex_valid && (ex_dREN || ex_dWEN);
      st       = memop && ex_dWEN;
      ld       = memop && !ex_dWEN;
      ll       = ld && ex_ll;
      sc       = st && ex_sc;
      lm       = m_link_valid && (m_link_addr == ex_addr[31:2]);
      halt_now = !m_halted && (k == 0) && ex_valid && ex_halt;
      req      = !m_halted && memop && !(sc && !lm) && !halt_now;
      stall    = req && !hit;
      #2;
      check_eq("dmemREN", {31'h0, dc_if.dmemREN}, {31'h0, req && ld});
      check_eq("dmemWEN", {31'h0, dc_if.dmemWEN}, {31'h0, req && st});
      check_eq("mem_stall", {31'h0, mem_stall}, {31'h0, stall});
      if (req) begin
        check_eq("dmemaddr", dc_if.dmemaddr, {ex_addr[31:2], 2'b00});
        check_eq("dmemstore", dc_if.dmemstore, ex_store);
      end
      @(posedge CLK);
      if (req && ll && hit) begin
        m_link_addr  = ex_addr[31:2];
        m_link_valid = !(inv && inv_addr[31:2] == ex_addr[31:2]);
      end else if ((req && sc && hit) || (inv && inv_addr[31:2] == m_link_addr)) begin
        m_link_valid = 1'b0;
      end
      if (m_halted || stall) begin
        e_valid = 0; e_regwen = 0; e_halt = 0;
      end else begin
        e_valid = ex_valid; e_regwen = ex_regwen; e_halt = halt_now;
        e_fm = ex_final_mux; e_nma = ex_next_memaddr; e_ut = ex_u_type; e_rd = ex_rd;
        e_load = (req && ld) ? dl : 32'h0;
        e_out  = sc ? ((req && hit) ? 32'h1 : 32'h0) : ex_out_port;
        if (halt_now) m_halted = 1'b1;
      end
      #1 check_wb();
      @(negedge CLK);
      if (!stall) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, a;
    dc_if.dhit = 0; dc_if.dload = '0; dc_if.ccinv = 0; dc_if.ccsnoopaddr = '0;
    set_ex(1, 1, 0, 0, 0, 0, 32'h104, 32'h0);
    #1 nRST = 1'b0;
    #2;
    check_eq("rst_dmemREN", {31'h0, dc_if.dmemREN}, 32'h0);
    check_eq("rst_mem_stall", {31'h0, mem_stall}, 32'h0);
    check_wb();
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    run_op(3, -1, 32'h0);                            // LW 0x104, 3-cycle miss

    set_ex(1, 1, 0, 1, 0, 0, 32'h200, 32'h0); run_op(0, -1, 32'h0);  // LL
    set_ex(1, 0, 1, 0, 1, 0, 32'h200, 32'h5); run_op(0, -1, 32'h0);  // SC ok
    set_ex(1, 0, 1, 0, 1, 0, 32'h200, 32'h5); run_op(0, -1, 32'h0);  // SC fails

    set_ex(1, 1, 0, 1, 0, 0, 32'h200, 32'h0); run_op(0, -1, 32'h0);
    set_ex(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);   run_op(0, 0, 32'h203);
    set_ex(1, 0, 1, 0, 1, 0, 32'h200, 32'h7); run_op(0, -1, 32'h0);
    set_ex(1, 1, 0, 1, 0, 0, 32'h200, 32'h0); run_op(0, -1, 32'h0);
    set_ex(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);   run_op(0, 0, 32'h300);
    set_ex(1, 0, 1, 0, 1, 0, 32'h200, 32'h7); run_op(0, -1, 32'h0);

    // SC waiting in the miss state is killed by a matching snoop
    set_ex(1, 1, 0, 1, 0, 0, 32'h200, 32'h0); run_op(0, -1, 32'h0);
    set_ex(1, 0, 1, 0, 1, 0, 32'h200, 32'h9); run_op(3, 1, 32'h200);

    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      a = pick_addr();
      case ($urandom_range(0, 6))
        0:       set_ex(0, r[0], r[1], r[2], r[3], 0, a, $urandom);
        1:       set_ex(1, 0, 0, 0, 0, 0, a, $urandom);
        2:       set_ex(1, 1, 0, 0, 0, 0, a, $urandom);
        3:       set_ex(1, 0, 1, 0, 0, 0, a, $urandom);
        4:       set_ex(1, 1, 0, 1, 0, 0, a, $urandom);
        5:       set_ex(1, 0, 1, 0, 1, 0, a, $urandom);
        default: set_ex(1, 1, 1, r[2], r[3], 0, a, $urandom);
      endcase
      run_op(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), pick_addr());
    end

    // Reset during a miss clears the link and drops requests at once
    set_ex(1, 1, 0, 1, 0, 0, 32'h200, 32'h0); run_op(0, -1, 32'h0);
    set_ex(1, 1, 0, 0, 0, 0, 32'h104, 32'h0);
    dc_if.dhit = 0; dc_if.ccinv = 0;
    #2 check_eq("wait_mem_stall", {31'h0, mem_stall}, 32'h1);
    @(posedge CLK);
    e_valid = 0; e_regwen = 0; e_halt = 0;
    #1 check_wb();
    #1 nRST = 1'b0;
    #1;
    check_eq("rstwait_dmemREN", {31'h0, dc_if.dmemREN}, 32'h0);
    check_eq("rstwait_mem_stall", {31'h0, mem_stall}, 32'h0);
    m_link_valid = 0; m_link_addr = '0; m_halted = 0;
    e_fm = '0; e_load = '0; e_out = '0; e_nma = '0; e_ut = '0; e_rd = '0;
    check_wb();
    @(negedge CLK);
    nRST = 1'b1;
    set_ex(1, 0, 1, 0, 1, 0, 32'h200, 32'h3); run_op(0, -1, 32'h0);  // link was cleared

    set_ex(1, 0, 0, 0, 0, 1, 32'h0, 32'h0); run_op(0, -1, 32'h0);    // HALT
    for (int i = 0; i < 3; i++) begin
      set_ex(1, 1, 0, 0, 0, 0, 32'h104, 32'h0); run_op(0, -1, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller sitting between the EX/MEM latch and the writeback datapath. It issues data-memory requests to the per-core dcache, waits on the `dhit` handshake while stalling the upstream pipe, and tracks the LL/SC link register against coherence invalidations. It registers the MEM/WB fields the writeback stage consumes: `final_mux`, `dmemload`, `out_port`, `next_memaddr`, `u_type` and `temp_halt`.

## Interface
No parameters.

- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX/MEM holds a real instruction
- ex_dREN, ex_dWEN  in  1 each  load / store
- ex_ll, ex_sc  in  1 each  load-linked (with dREN) / store-conditional (with dWEN)
- ex_addr  in  32  byte address; bits [1:0] ignored
- ex_store  in  32  store data
- ex_final_mux  in  3  writeback select, passed through
- ex_out_port, ex_next_memaddr, ex_u_type  in  32 each  passed through
- ex_halt  in  1  halt instruction
- ex_rd  in  5  destination register
- ex_regwen  in  1  destination write enable
- dhit  in  1  dcache completes current request this cycle
- dload  in  32  read data, valid with dhit
- ccinv  in  1  coherence invalidate
- ccsnoopaddr  in  32  invalidated address
- dmemREN, dmemWEN  out  1 each  request to dcache
- dmemaddr  out  32  {ex_addr[31:2], 2'b00}
- dmemstore  out  32  ex_store
- mem_stall  out  1  freeze PC/IF/ID/EX and EX/MEM latch
- wb_valid, wb_regwen, wb_temp_halt  out  1 each  MEM/WB fields
- wb_final_mux  out  3
- wb_dmemload, wb_out_port, wb_next_memaddr, wb_u_type  out  32 each
- wb_rd  out  5

## Operation
- States: IDLE, WAIT, HALTED. Link register holds `link_valid` (1 bit) and `link_addr` (word address, bits [31:2]).
- A memory op is `ex_valid & (ex_dREN | ex_dWEN)`.
- **IDLE**
  - Non-memory op or bubble: completes in the current cycle.
  - Memory op: drive the request combinationally. dhit=1 completes it the same cycle. dhit=0 raises mem_stall and moves to WAIT.
  - SC fail check at issue: if `!link_valid` or `link_addr != ex_addr[31:2]`:
    - no request and no stall; completes immediately;
    - wb_out_port=0, with wb_final_mux passed through.
- **WAIT**
  - Hold dmemREN/dmemWEN/dmemaddr/dmemstore (ex inputs are frozen by the stall). mem_stall=1 until the dhit cycle, when mem_stall=0 and the op completes → IDLE.
  - If a matching ccinv clears the link while an SC waits: drop dmemWEN the next cycle and complete as failure (wb_out_port=0). A dhit in the same cycle as that ccinv counts as success.
- **Completion** latches at the clock edge:
  - wb_valid=ex_valid, wb_rd, wb_regwen, wb_final_mux, wb_next_memaddr, wb_u_type.
  - wb_dmemload = dload for reads, else 0.
  - wb_out_port = ex_out_port, except for SC, where it is 1 on success and 0 on failure.
- **Stall cycles** latch a bubble: wb_valid=0, wb_regwen=0, wb_temp_halt=0. The other wb fields hold.
- **Halt**: `ex_valid & ex_halt` in IDLE completes with wb_temp_halt=1 → HALTED. HALTED issues no requests, holds mem_stall=0, latches bubbles, and is left only by reset.
- **Link register**
  - LL dhit: link_valid=1, link_addr=ex_addr[31:2].
  - Successful SC: link_valid=0.
  - ccinv with ccsnoopaddr[31:2]==link_addr: link_valid=0.
  - ccinv matching in the same cycle as an LL completion: invalidation wins, link_valid=0.
  - Plain stores do not touch the link.
- dmemREN and dmemWEN are never both 1. If ex_dREN & ex_dWEN, treat it as a store.

## Timing
- Reset values:
  - state IDLE, link_valid=0, link_addr=0;
  - all wb_* outputs 0;
  - dmemREN, dmemWEN, mem_stall 0 (combinational from the IDLE state plus ex inputs);
  - dmemaddr and dmemstore follow the inputs.
- Non-memory op or dcache hit: 0 stall cycles; wb_* valid the cycle after the op is presented.
- Miss with dhit in cycle N (op presented in cycle 0): mem_stall=1 in cycles 0..N-1 and 0 in cycle N; wb_* valid in N+1.
- mem_stall and the dcache requests are combinational and have no registered delay. wb_* and the link register are registered.
- Reset asserted mid-WAIT: immediately IDLE, requests deassert asynchronously, link cleared.

## Test plan
- Reset with ex_valid=1 LW pending → dmemREN=0, mem_stall=0, wb_valid=0, link_valid=0. After release the LW issues.
- LW 0x104, dhit after 3 cycles, dload=0xDEADBEEF → mem_stall high 3 cycles, dmemaddr=0x104, then wb_dmemload=0xDEADBEEF, wb_valid=1. The 3 prior wb_valid are 0.
- LL 0x200 hit, then SC 0x200 data 0x5 → dmemWEN=1, dmemstore=0x5, wb_out_port=1, link_valid=0. A second SC 0x200 → no dmemWEN, wb_out_port=0, 0 stall.
- LL 0x200, then ccinv with ccsnoopaddr=0x203, then SC 0x200 → SC fails with no request. Repeat with ccsnoopaddr=0x300 → SC succeeds.
- SC 0x200 in WAIT; ccinv 0x200 arrives with dhit=0 → dmemWEN drops next cycle, wb_out_port=0, stall released.
- HALT with ex_valid=1 → wb_temp_halt=1 for one latch. A following LW never asserts dmemREN and mem_stall stays 0.
